// File: rtl/dump_pkg.sv
// Shared types and constants for the halt-triggered memory dumper.
package dump_pkg;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned DWORD_BYTES = 8;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    OUT,
    DONE
  } state_e;

  // Byte address of 64-bit entry idx, wrapping modulo 2^16.
  function automatic logic [ADDR_W-1:0] entry_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
    return ADDR_W'(base + ADDR_W'(idx) * ADDR_W'(DWORD_BYTES));
  endfunction

endpackage

// File: rtl/halt_mem_dumper.sv
// On a CPU halt, reads COUNT 64-bit entries from the data SRAM as word pairs
// and streams them out over a valid/ready interface.
module halt_mem_dumper
  import dump_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned COUNT     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic [15:0] mem_addr,
  output logic [3:0]  mem_w_en,
  input  logic [31:0] mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [15:0] out_addr,
  output logic [7:0]  out_index,
  output logic        busy,
  output logic        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [2*WORD_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  // Next-state logic; outputs are decoded from the next state so they register
  // in step with the state they belong to.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_index_d = out_index_q;
    mem_addr_d  = '0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          idx_d   = '0;
          state_d = (COUNT == 0) ? DONE : RD_LO;
        end
      end
      RD_LO:  state_d = RD_HI;
      RD_HI: begin
        out_data_d[WORD_W-1:0] = mem_read_data;
        state_d                = CAP_HI;
      end
      CAP_HI: begin
        out_data_d[2*WORD_W-1:WORD_W] = mem_read_data;
        out_addr_d                    = entry_addr(BASE_ADDR, idx_q);
        out_index_d                   = idx_q;
        state_d                       = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RD_LO;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      RD_LO:   mem_addr_d = entry_addr(BASE_ADDR, idx_d);
      RD_HI:   mem_addr_d = ADDR_W'(entry_addr(BASE_ADDR, idx_d) + ADDR_W'(WORD_BYTES));
      default: mem_addr_d = '0;
    endcase

    out_valid_d = (state_d == OUT);
    busy_d      = (state_d inside {RD_LO, RD_HI, CAP_HI, OUT});
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_w_en  = 4'b0000;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_index = out_index_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_halt_mem_dumper.sv
// Self-checking bench: three dumper configurations share one SRAM model; each
// dump is checked cycle by cycle against entries computed from the memory image.
module tb_halt_mem_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        hl   [3];
  logic        rdy  [3];
  logic [15:0] ma   [3];
  logic [3:0]  wen  [3];
  logic [31:0] rd   [3];
  logic        ov   [3];
  logic [63:0] od   [3];
  logic [15:0] oa   [3];
  logic [7:0]  oi   [3];
  logic        bz   [3];
  logic        dn   [3];

  logic [31:0] mem [16384];
  int cyc    = 0;
  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data valid the cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rd[i] <= mem[ma[i][15:2]];
  end

  halt_mem_dumper #(.BASE_ADDR(16'h0000), .COUNT(7)) u0 (
    .clk(clk), .rst(rst), .halt(hl[0]), .mem_addr(ma[0]), .mem_w_en(wen[0]),
    .mem_read_data(rd[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]),
    .out_addr(oa[0]), .out_index(oi[0]), .busy(bz[0]), .done(dn[0]));

  halt_mem_dumper #(.BASE_ADDR(16'hFFF8), .COUNT(2)) u1 (
    .clk(clk), .rst(rst), .halt(hl[1]), .mem_addr(ma[1]), .mem_w_en(wen[1]),
    .mem_read_data(rd[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]),
    .out_addr(oa[1]), .out_index(oi[1]), .busy(bz[1]), .done(dn[1]));

  halt_mem_dumper #(.BASE_ADDR(16'h0000), .COUNT(0)) u2 (
    .clk(clk), .rst(rst), .halt(hl[2]), .mem_addr(ma[2]), .mem_w_en(wen[2]),
    .mem_read_data(rd[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(od[2]),
    .out_addr(oa[2]), .out_index(oi[2]), .busy(bz[2]), .done(dn[2]));

  function automatic logic [15:0] base_of(input int s);
    return (s == 1) ? 16'hFFF8 : 16'h0000;
  endfunction

  function automatic int cnt_of(input int s);
    return (s == 0) ? 7 : (s == 1) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("mem_w_en", 64'(wen[i]), 64'h0);
  endtask

  task automatic check_idle(input int s, input string tag);
    chk({tag, "_valid"}, 64'(ov[s]), 64'h0);
    chk({tag, "_done"},  64'(dn[s]), 64'h0);
    chk({tag, "_busy"},  64'(bz[s]), 64'h0);
    chk({tag, "_maddr"}, 64'(ma[s]), 64'h0);
    chk({tag, "_data"},  od[s],      64'h0);
    chk({tag, "_oaddr"}, 64'(oa[s]), 64'h0);
    chk({tag, "_index"}, 64'(oi[s]), 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) check_idle(i, "reset");
  endtask

  // Reference: entry k sits at base+8k (mod 2^16), value {word@+4, word@+0};
  // beat k is valid 4+4k cycles after halt is driven, plus all earlier stalls.
  task automatic run_dump(input int s, input int stall_pct, input int abort_beat,
                          input int stall_beat, input bit hold);
    logic [15:0] base, a, a4;
    logic [63:0] ed;
    int c, t0, stalls, local_st;
    bit r;
    base   = base_of(s);
    c      = cnt_of(s);
    stalls = 0;
    t0     = cyc;
    hl[s]  = 1'b1;
    tick();
    if (!hold) hl[s] = 1'b0;
    if (c == 0) begin
      for (int i = 0; i < 4; i++) begin
        chk("c0_done",  64'(dn[s]), 64'h1);
        chk("c0_valid", 64'(ov[s]), 64'h0);
        chk("c0_busy",  64'(bz[s]), 64'h0);
        tick();
      end
      hl[s] = 1'b0;
      return;
    end
    for (int k = 0; k < c; k++) begin
      a  = 16'(base + 16'(k * 8));
      a4 = 16'(a + 16'd4);
      ed = {mem[a4[15:2]], mem[a[15:2]]};
      chk("rdlo_maddr", 64'(ma[s]), 64'(a));
      chk("rdlo_valid", 64'(ov[s]), 64'h0);
      chk("rdlo_busy",  64'(bz[s]), 64'h1);
      tick();
      chk("rdhi_maddr", 64'(ma[s]), 64'(a4));
      chk("rdhi_valid", 64'(ov[s]), 64'h0);
      tick();
      chk("cap_valid", 64'(ov[s]), 64'h0);
      chk("cap_busy",  64'(bz[s]), 64'h1);
      if (k == abort_beat) begin
        hl[s] = 1'b0;
        rst   = 1'b0;
        tick();
        rst   = 1'b1;
        check_idle(s, "abort");
        return;
      end
      tick();
      local_st = 0;
      for (int w = 0; w < 12; w++) begin
        chk("out_valid", 64'(ov[s]), 64'h1);
        chk("out_data",  od[s],      ed);
        chk("out_addr",  64'(oa[s]), 64'(a));
        chk("out_index", 64'(oi[s]), 64'(k));
        chk("out_maddr", 64'(ma[s]), 64'h0);
        chk("out_busy",  64'(bz[s]), 64'h1);
        chk("out_done",  64'(dn[s]), 64'h0);
        chk("beat_cycle", 64'(cyc), 64'(t0 + 4 + 4 * k + stalls));
        if (k == stall_beat) r = (local_st >= 5);
        else                 r = ($urandom_range(99) >= stall_pct) || (local_st >= 8);
        rdy[s] = r;
        tick();
        rdy[s] = 1'b0;
        if (r) break;
        stalls++;
        local_st++;
      end
    end
    chk("end_done",  64'(dn[s]), 64'h1);
    chk("end_busy",  64'(bz[s]), 64'h0);
    chk("end_valid", 64'(ov[s]), 64'h0);
    chk("end_maddr", 64'(ma[s]), 64'h0);
    chk("done_cycle", 64'(cyc), 64'(t0 + 4 * c + stalls + 1));
    hl[s] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_sticky", 64'(dn[s]), 64'h1);
      chk("done_valid",  64'(ov[s]), 64'h0);
      chk("done_maddr",  64'(ma[s]), 64'h0);
    end
    hl[s] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hl[i]  = 1'b0;
      rdy[i] = 1'b0;
    end
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    tick();
    do_reset();

    // Directed: entries 100+k, halt driven at cycle 10, consumer always ready.
    for (int k = 0; k < 7; k++) begin
      mem[2 * k]     = 32'(100 + k);
      mem[2 * k + 1] = 32'h0;
    end
    while (cyc < 10) tick();
    run_dump(0, 0, -1, -1, 1'b0);

    // Negative entry plus a 5-cycle stall on beat 2.
    do_reset();
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[0] = 32'hFFFF_FFFE;
    mem[1] = 32'hFFFF_FFFF;
    run_dump(0, 0, -1, 2, 1'b1);

    // Reset during beat 3 capture, then a fresh dump from index 0.
    do_reset();
    run_dump(0, 40, 3, -1, 1'b0);
    repeat (2) tick();
    run_dump(0, 40, -1, -1, 1'b0);

    // Address wrap past 16'hFFFF.
    do_reset();
    run_dump(1, 30, -1, -1, 1'b1);

    // Empty dump.
    do_reset();
    run_dump(2, 0, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c0_never_valid", 64'(ov[2]), 64'h0);
    end

    // Randomized images, stall rates and halt lengths.
    for (int n = 0; n < 4; n++) begin
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[16382] = $urandom;
      mem[16383] = $urandom;
      repeat ($urandom_range(3)) tick();
      run_dump(n % 2, $urandom_range(60), -1, -1, 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
